// File: rtl/inst_mem_loader.sv
// Byte-serial loader and instruction RAM: packs little-endian bytes into words, holds the core in
// reset until ld_last, then serves combinational fetches. Define INST_MEM_LOADER_CHECKSUM_EN for a checksum output.
module inst_mem_loader #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    input  logic [31:0]   inst_addr,
    output logic [31:0]   inst,
    output logic          cpu_rst_n,
    output logic [AW:0]   words_loaded,
    output logic          overflow
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]   checksum
`endif
);

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {LOAD, RUN} state_e;

    state_e        state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   asm_q, asm_d;
    logic [AW:0]   wl_q, wl_d;
    logic          ovf_q, ovf_d;
    logic          cpu_rst_n_q;
    logic [31:0]   mem [DEPTH];

    logic          xfer, commit, we;
    logic [31:0]   word;
    logic [29:0]   addr_w;
    logic [AW-1:0] idx;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        wl_d    = wl_q;
        ovf_d   = ovf_q;
        // Unreceived upper lanes are already zero because the assembly register clears on commit.
        word    = asm_q | ({24'b0, ld_byte} << {lane_q, 3'b000});
        xfer    = ld_valid && (state_q == LOAD);
        commit  = xfer && ((lane_q == 2'd3) || ld_last);
        we      = commit && (wl_q != FULL);
        if (xfer) begin
            lane_d = lane_q + 2'd1;
            asm_d  = word;
            if (commit) begin
                lane_d = '0;
                asm_d  = '0;
                if (wl_q == FULL) ovf_d = 1'b1;
                else              wl_d  = wl_q + 1'b1;
            end
            if (ld_last) state_d = RUN;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= LOAD;
            lane_q      <= '0;
            asm_q       <= '0;
            wl_q        <= '0;
            ovf_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            wl_q        <= wl_d;
            ovf_q       <= ovf_d;
            cpu_rst_n_q <= (state_d == RUN);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && we) mem[wl_q[AW-1:0]] <= word;
    end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [31:0] cs_q;
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) cs_q <= '0;
        else if (we)    cs_q <= cs_q + word;
    end
    assign checksum = cs_q;
`endif

    // Word address drops the byte offset; anything above the RAM window reads as NOP.
    assign addr_w = 30'(inst_addr >> 2);
    assign idx    = addr_w[AW-1:0];

    always_comb begin
        inst = NOP;
        if ((state_q == RUN) && !(|addr_w[29:AW]) && ({1'b0, idx} < wl_q))
            inst = mem[idx];
    end

    assign ld_ready     = (state_q == LOAD);
    assign cpu_rst_n    = cpu_rst_n_q;
    assign words_loaded = wl_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized and directed bench for inst_mem_loader: a 4096-word and a 4-word instance share stimulus
// and are checked against a byte-list packing model.
module tb_inst_mem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ld_valid, ld_last;
    logic [7:0]  ld_byte;
    logic [31:0] inst_addr;
    logic        rdy_b, rdy_s, cpu_b, cpu_s, ovf_b, ovf_s;
    logic [31:0] inst_b, inst_s;
    logic [12:0] wl_b;
    logic [2:0]  wl_s;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [31:0] cs_b, cs_s;
`endif

    inst_mem_loader #(.DEPTH(4096), .AW(12)) u_big (
        .sys_clk(clk), .sys_rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(rdy_b),
        .ld_byte(ld_byte), .ld_last(ld_last), .inst_addr(inst_addr), .inst(inst_b),
        .cpu_rst_n(cpu_b), .words_loaded(wl_b), .overflow(ovf_b)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

    inst_mem_loader #(.DEPTH(4), .AW(2)) u_small (
        .sys_clk(clk), .sys_rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(rdy_s),
        .ld_byte(ld_byte), .ld_last(ld_last), .inst_addr(inst_addr), .inst(inst_s),
        .cpu_rst_n(cpu_s), .words_loaded(wl_s), .overflow(ovf_s)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        , .checksum(cs_s)
`endif
    );

    int nchk = 0;
    int npass = 0;

    // observations gathered while bytes are being streamed
    bit bad_rdy_b, bad_rdy_s, early_cpu, bad_nop;

    logic [31:0] exp_w[$];

    task automatic model(input logic [7:0] q[$], input int depth, output int wl, output bit ovf,
                         output logic [31:0] cs);
        int nw;
        nw = (q.size() + 3) / 4;
        exp_w.delete();
        cs = '0;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] wd;
            wd = '0;
            for (int j = 0; j < 4; j++)
                if (4*w + j < q.size()) wd[8*j +: 8] = q[4*w + j];
            exp_w.push_back(wd);
            if (w < depth) cs = cs + wd;
        end
        wl  = (nw < depth) ? nw : depth;
        ovf = (nw > depth);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [7:0] q[$], input bit last_on_end, input int maxgap);
        bad_rdy_b = 0; bad_rdy_s = 0; early_cpu = 0; bad_nop = 0;
        foreach (q[i]) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                ld_valid = 1'b0; ld_last = 1'b0;
            end
            @(negedge clk);
            inst_addr = $urandom;
            #1;
            if (!rdy_b) bad_rdy_b = 1;
            if (!rdy_s) bad_rdy_s = 1;
            if (cpu_b || cpu_s) early_cpu = 1;
            if (inst_b !== NOP || inst_s !== NOP) bad_nop = 1;
            ld_valid = 1'b1;
            ld_byte  = q[i];
            ld_last  = last_on_end && (i == q.size() - 1);
            @(posedge clk);
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        inst_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0; inst_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        nchk++;
        if ({cpu_b, cpu_s, ovf_b, ovf_s, rdy_b, rdy_s} !== 6'b000011)
            $display("FAIL reset_flags: got %b want 000011", {cpu_b, cpu_s, ovf_b, ovf_s, rdy_b, rdy_s});
        else npass++;
        nchk++;
        if (wl_b !== 13'd0 || wl_s !== 3'd0)
            $display("FAIL reset_words: got %0d/%0d want 0/0", wl_b, wl_s);
        else npass++;
        nchk++;
        if (inst_b !== NOP || inst_s !== NOP)
            $display("FAIL reset_fetch_nop: got %h/%h want %h", inst_b, inst_s, NOP);
        else npass++;
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_reset();
        drive(q, 1, 0);
        nchk++;
        if (early_cpu || bad_rdy_b || bad_nop)
            $display("FAIL basic_during_load: early_cpu=%0d not_ready=%0d non_nop=%0d want 0 0 0",
                     early_cpu, bad_rdy_b, bad_nop);
        else npass++;
        nchk++;
        if (cpu_b !== 1'b1 || rdy_b !== 1'b0)
            $display("FAIL basic_run: cpu_rst_n=%b ld_ready=%b want 1 0", cpu_b, rdy_b);
        else npass++;
        nchk++;
        if (wl_b !== 13'd2) $display("FAIL basic_words: got %0d want 2", wl_b);
        else npass++;
        fetch(32'd0);
        nchk++;
        if (inst_b !== 32'h0010_0513) $display("FAIL basic_mem0: got %h want 00100513", inst_b);
        else npass++;
        fetch(32'd4);
        nchk++;
        if (inst_b !== 32'h0020_0593) $display("FAIL basic_mem1: got %h want 00200593", inst_b);
        else npass++;
        fetch(32'd6);
        nchk++;
        if (inst_b !== 32'h0020_0593) $display("FAIL basic_addr6: got %h want 00200593", inst_b);
        else npass++;
    endtask

    task automatic test_partial();
        logic [7:0] q[$];
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAB};
        do_reset();
        drive(q, 1, 3);
        nchk++;
        if (wl_b !== 13'd2) $display("FAIL partial_words: got %0d want 2", wl_b);
        else npass++;
        fetch(32'd0);
        nchk++;
        if (inst_b !== 32'h0403_0201) $display("FAIL partial_mem0: got %h want 04030201", inst_b);
        else npass++;
        fetch(32'd4);
        nchk++;
        if (inst_b !== 32'h0000_00AB) $display("FAIL partial_mem1: got %h want 000000ab", inst_b);
        else npass++;
        fetch(32'd8);
        nchk++;
        if (inst_b !== NOP) $display("FAIL partial_past_end: got %h want %h", inst_b, NOP);
        else npass++;
    endtask

    task automatic test_overflow();
        logic [7:0]  q[$];
        int          ewl;
        bit          eovf;
        logic [31:0] ecs;
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        do_reset();
        drive(q, 1, 1);
        model(q, 4, ewl, eovf, ecs);
        nchk++;
        if (bad_rdy_s) $display("FAIL ovf_ready_drop: ld_ready fell during load, want held 1");
        else npass++;
        nchk++;
        if (int'(wl_s) != ewl || ovf_s !== eovf)
            $display("FAIL ovf_small: words=%0d ovf=%b want %0d %b", wl_s, ovf_s, ewl, eovf);
        else npass++;
        nchk++;
        if (cpu_s !== 1'b1 || rdy_s !== 1'b0)
            $display("FAIL ovf_run: cpu_rst_n=%b ld_ready=%b want 1 0", cpu_s, rdy_s);
        else npass++;
        nchk++;
        if (wl_b !== 13'd5 || ovf_b !== 1'b0)
            $display("FAIL ovf_big: words=%0d ovf=%b want 5 0", wl_b, ovf_b);
        else npass++;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(4*i));
            nchk++;
            if (inst_s !== exp_w[i]) $display("FAIL ovf_mem%0d: got %h want %h", i, inst_s, exp_w[i]);
            else npass++;
        end
        fetch(32'd16);
        nchk++;
        if (inst_s !== NOP) $display("FAIL ovf_beyond_window: got %h want %h", inst_s, NOP);
        else npass++;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        nchk++;
        if (cs_s !== ecs) $display("FAIL ovf_checksum: got %h want %h", cs_s, ecs);
        else npass++;
`endif
    endtask

    task automatic test_reset_midload();
        logic [7:0] q[$];
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        do_reset();
        drive(q, 0, 0);
        // reset coincides with a byte carrying ld_last; reset must win
        @(negedge clk);
        rst_n = 1'b0; ld_valid = 1'b1; ld_byte = 8'h55; ld_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        nchk++;
        if (rdy_b !== 1'b1 || cpu_b !== 1'b0 || wl_b !== 13'd0)
            $display("FAIL midreset_state: ready=%b cpu=%b words=%0d want 1 0 0", rdy_b, cpu_b, wl_b);
        else npass++;
        q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        drive(q, 1, 0);
        nchk++;
        if (early_cpu || cpu_b !== 1'b1)
            $display("FAIL midreset_cpu: early=%0d final=%b want 0 1", early_cpu, cpu_b);
        else npass++;
        nchk++;
        if (wl_b !== 13'd1) $display("FAIL midreset_words: got %0d want 1", wl_b);
        else npass++;
        fetch(32'd0);
        nchk++;
        if (inst_b !== 32'hDEAD_BEEF) $display("FAIL midreset_mem0: got %h want deadbeef", inst_b);
        else npass++;
    endtask

    task automatic test_run_idle();
        bit saw_ready;
        saw_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_byte = 8'($urandom); ld_last = 1'($urandom);
            #1;
            if (rdy_b || rdy_s) saw_ready = 1;
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        nchk++;
        if (saw_ready) $display("FAIL idle_ready: ld_ready seen high in RUN, want 0");
        else npass++;
        nchk++;
        if (wl_b !== 13'd1 || cpu_b !== 1'b1)
            $display("FAIL idle_state: words=%0d cpu=%b want 1 1", wl_b, cpu_b);
        else npass++;
        fetch(32'd0);
        nchk++;
        if (inst_b !== 32'hDEAD_BEEF) $display("FAIL idle_mem0: got %h want deadbeef", inst_b);
        else npass++;
        fetch(32'h0001_0000);
        nchk++;
        if (inst_b !== NOP || inst_s !== NOP)
            $display("FAIL idle_out_of_range: got %h/%h want %h", inst_b, inst_s, NOP);
        else npass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0]  q[$];
            int          n, ewl_b, ewl_s;
            bit          eovf_b, eovf_s;
            logic [31:0] ecs_b, ecs_s;
            n = int'($urandom_range(24, 1));
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_reset();
            drive(q, 1, 2);
            model(q, 4, ewl_s, eovf_s, ecs_s);
            model(q, 4096, ewl_b, eovf_b, ecs_b);
            nchk++;
            if (early_cpu || bad_rdy_b || bad_rdy_s || bad_nop || cpu_b !== 1'b1)
                $display("FAIL rnd%0d_handshake: early=%0d nrdy=%0d/%0d nonnop=%0d cpu=%b want 0 0/0 0 1",
                         it, early_cpu, bad_rdy_b, bad_rdy_s, bad_nop, cpu_b);
            else npass++;
            nchk++;
            if (int'(wl_b) != ewl_b || ovf_b !== eovf_b || int'(wl_s) != ewl_s || ovf_s !== eovf_s)
                $display("FAIL rnd%0d_counts: big=%0d/%b small=%0d/%b want %0d/%b %0d/%b",
                         it, wl_b, ovf_b, wl_s, ovf_s, ewl_b, eovf_b, ewl_s, eovf_s);
            else npass++;
            for (int w = 0; w < ewl_b; w++) begin
                fetch(32'(4*w) | 32'($urandom_range(3, 0)));
                nchk++;
                if (inst_b !== exp_w[w])
                    $display("FAIL rnd%0d_big_w%0d: got %h want %h", it, w, inst_b, exp_w[w]);
                else npass++;
                if (w < ewl_s) begin
                    nchk++;
                    if (inst_s !== exp_w[w])
                        $display("FAIL rnd%0d_small_w%0d: got %h want %h", it, w, inst_s, exp_w[w]);
                    else npass++;
                end
            end
            fetch(32'(4*ewl_b));
            nchk++;
            if (inst_b !== NOP) $display("FAIL rnd%0d_past_end: got %h want %h", it, inst_b, NOP);
            else npass++;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            nchk++;
            if (cs_b !== ecs_b || cs_s !== ecs_s)
                $display("FAIL rnd%0d_checksum: got %h/%h want %h/%h", it, cs_b, cs_s, ecs_b, ecs_s);
            else npass++;
`endif
        end
    endtask

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] q[$];
        q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_reset();
        nchk++;
        if (cs_b !== 32'd0) $display("FAIL cs_reset: got %h want 00000000", cs_b);
        else npass++;
        drive(q, 1, 0);
        repeat (3) @(negedge clk);
        nchk++;
        if (cs_b !== 32'h0030_0AA6) $display("FAIL cs_basic: got %h want 00300aa6", cs_b);
        else npass++;
        do_reset();
        nchk++;
        if (cs_b !== 32'd0) $display("FAIL cs_after_reset: got %h want 00000000", cs_b);
        else npass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_reset_midload();
        test_run_idle();
        test_random();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
